ssp_tx_fifo: RTL



---
 rtl/ssp_pkg.sv | 8 +
 rtl/data_sync.sv | 37 +++
 rtl/ssp_tx_fifo.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ssp_pkg.sv
// Shared SSP constants used by both the transmit and receive FIFOs.
package ssp_pkg;

    localparam int SSP_DATA_WIDTH = 8;
    localparam int SSP_ADDR_WIDTH = 2;
    localparam int SSP_FIFO_DEPTH = 1 << SSP_ADDR_WIDTH;

endpackage : ssp_pkg

// File: rtl/data_sync.sv
// Two-flop synchroniser for a single asynchronous level signal.
// Both stages are visible so the caller can build an edge detector
// from the first stage against the second.
module data_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic stage1,
    output logic stage2
);

    logic stage1_q;
    logic stage1_d;
    logic stage2_q;
    logic stage2_d;

    // Each stage simply takes the value of the one before it.
    always_comb begin
        stage1_d = d;
        stage2_d = stage1_q;
    end

    // Synchronous active-low reset clears both stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign stage1 = stage1_q;
    assign stage2 = stage2_q;

endmodule : data_sync

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: the APB host pushes bytes, the serial shifter pops them
// by raising an asynchronous request that is synchronised and edge-detected here.
module ssp_tx_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = SSP_DATA_WIDTH,
    parameter int ADDR_WIDTH = SSP_ADDR_WIDTH
) (
    input  logic                  i_PCLK,
    input  logic                  i_CLEAR,
    input  logic                  i_PSEL,
    input  logic                  i_PWRITE,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    input  logic                  i_REQ,
    output logic [DATA_WIDTH-1:0] o_TXDATA,
    output logic                  o_TXVALID,
    output logic                  o_POP,
    output logic                  o_SSPTXINTR,
    output logic                  o_OVERRUN
);

    localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d;
    logic [DATA_WIDTH-1:0] txdata_q;
    logic [DATA_WIDTH-1:0] txdata_d;
    logic                  pop_q;
    logic                  pop_d;
    logic                  overrun_q;
    logic                  overrun_d;

    logic req_s1;
    logic req_s2;
    logic sync_rst_n;
    logic empty;
    logic full;
    logic push_req;
    logic push;
    logic rise;
    logic pop;

    assign sync_rst_n = !i_CLEAR;

    data_sync u_req_sync (
        .clk    (i_PCLK),
        .rst_n  (sync_rst_n),
        .d      (i_REQ),
        .stage1 (req_s1),
        .stage2 (req_s2)
    );

    // Flags and handshake qualifiers all come from pre-edge state, so a push
    // into a full FIFO stays blocked even when a pop happens in the same cycle.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_FULL);
        push_req = i_PSEL & i_PWRITE;
        push     = push_req & !full;
        rise     = req_s1 & !req_s2;
        pop      = rise & !empty;
    end

    // Next-state for counter, pointers, output byte and status flags.
    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        txdata_d  = txdata_q;
        pop_d     = pop;
        overrun_d = overrun_q | (push_req & full);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            txdata_d = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State register; a clear wins over any push or pop in the same cycle.
    always_ff @(posedge i_PCLK) begin
        if (i_CLEAR) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            txdata_q  <= '0;
            pop_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            txdata_q  <= txdata_d;
            pop_q     <= pop_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array is never cleared; only the write is suppressed during clear.
    always_ff @(posedge i_PCLK) begin
        if (!i_CLEAR && push) begin
            mem_q[wr_ptr_q] <= i_PWDATA;
        end
    end

    assign o_TXDATA    = txdata_q;
    assign o_TXVALID   = !empty;
    assign o_POP       = pop_q;
    assign o_SSPTXINTR = full;
    assign o_OVERRUN   = overrun_q;

endmodule : ssp_tx_fifo
